// File: rtl/mem_store_pkg.sv
// Shared definitions for the narrowing store path: op encodings, FSM states
// and the legal range of the data-memory read latency.
package mem_store_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } store_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } store_state_e;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the narrowed store data into the word
// read back from memory (little-endian lanes).
module store_lane_merge
    import mem_store_pkg::*;
(
    input  store_op_e   op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged
);

    // Start from the read-back word and overwrite only the addressed lane(s).
    always_comb begin
        merged = rdata;
        case (op)
            ST_SW: merged = wdata;
            ST_SH: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            ST_SB: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Narrowing store unit for the multicycle MIPS datapath. SW writes directly;
// SH/SB read the word, merge the new lane and write it back.
// Optional feature: define STORE_MISALIGN_TRAP_EN to suppress misaligned
// SW/SH stores and flag them on misalign together with done.
module store_merge_unit
    import mem_store_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1  // legal range MEM_LAT_MIN..MEM_LAT_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    // Count value of the last WAIT cycle; the counter starts at 0 on entry.
    localparam logic [1:0] WaitLast = 2'(MEM_LAT - 1);

    store_state_e state_q, state_d;
    store_op_e    op_in, op_q;
    logic [31:0]  addr_q, wdata_q, rdata_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         accept, trap;

    assign op_in  = store_op_e'(op);
    assign accept = start && (state_q == StIdle);

`ifdef STORE_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = ((op_in == ST_SW) && (addr[1:0] != 2'b00)) ||
                  ((op_in == ST_SH) && addr[0]);

    // Remember whether the accepted request was suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mis_q <= 1'b0;
        else if (accept) mis_q <= trap;
    end

    assign misalign = (state_q == StDone) && mis_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    // Next-state logic and WAIT cycle counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if ((op_in == ST_RSV) || trap) state_d = StDone;
                    else if (op_in == ST_SW)       state_d = StWrite;
                    else                           state_d = StRead;
                end
            end
            StRead: begin
                state_d = StWait;
                cnt_d   = 2'd0;
            end
            StWait: begin
                if (cnt_q == WaitLast) state_d = StWrite;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches, loaded only on acceptance so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= ST_SW;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            op_q    <= op_in;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Merge register: capture read data at the end of the last WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if ((state_q == StWait) && (cnt_q == WaitLast)) begin
            rdata_q <= mem_rdata;
        end
    end

    store_lane_merge u_merge (
        .op     (op_q),
        .offset (addr_q[1:0]),
        .wdata  (wdata_q),
        .rdata  (rdata_q),
        .merged (mem_wdata)
    );

    // Strobes decode straight from the state so they fall with an async reset.
    assign ready    = (state_q == StIdle);
    assign mem_re   = (state_q == StRead);
    assign mem_we   = (state_q == StWrite);
    assign done     = (state_q == StDone);
    // addr_q only changes on acceptance, so this holds its last value in IDLE.
    assign mem_addr = {addr_q[31:2], 2'b00};

endmodule
